spm_conflict_serializer: RTL and testbench
==========================================

Name: spm_conflict_serializer

Overview:
- Sits between the scratchpad address-decode stage and the bank array.
- Accepts one vector request per handshake and splits it into bank-conflict-free issue beats.
- Loads: every lane that hits the same bank and entry as the lowest pending lane of that bank is served in the same beat (broadcast).
- Stores: at most one lane per bank per beat.
- Holds the pending-lane mask and iterates until the mask is empty, then raises out_last.

Parameters:
- NUM_LANES, `SM_PROCESSING_ELEMENTS (16), number of vector lanes.
- NUM_BANKS, `SM_MEMORY_BANKS (16), number of SPM banks.
- DATA_W, 32, lane data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_is_store  in  1  1 = store, 0 = load.
- in_bank_indexes  in  NUM_LANES x sm_bank_address_t  per-lane bank.
- in_bank_offsets  in  NUM_LANES x sm_entry_address_t  per-lane entry.
- in_data  in  NUM_LANES x DATA_W  store data.
- in_mask  in  NUM_LANES  active lanes.
- out_valid  out  1  issue beat valid.
- out_ready  in  1  bank array accepts the beat.
- out_is_store  out  1  captured in_is_store.
- out_bank_enable  out  NUM_BANKS  banks accessed this beat.
- out_bank_offset  out  NUM_BANKS x sm_entry_address_t  entry per enabled bank.
- out_bank_data  out  NUM_BANKS x DATA_W  store data per enabled bank.
- out_lane_mask  out  NUM_LANES  lanes served by this beat.
- out_last  out  1  this beat empties the pending mask.

Behaviour:
- States: IDLE, ISSUE.
- Reset (async, reset=0): state IDLE, pending 0, all captured registers 0. in_ready=1; out_valid, out_bank_enable, out_lane_mask and out_last all 0.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready, capture all in_* fields, set pending=in_mask, go to ISSUE.
- Latency: accept at cycle T; first beat valid at T+1. Minimum request occupancy is 2 cycles, because in_ready is low during the final beat (no back-to-back accept).
- ISSUE: out_valid=1. Outputs are combinational from registered state only, with no path from the in_* ports.
- Per bank b: lead(b) is the lowest-index pending lane with bank_index==b.
  - Load: lanes served by b are all pending lanes with the same bank and offset as lead(b).
  - Store: only lead(b) is served.
- out_bank_enable[b]=1 iff lead(b) exists. out_bank_offset[b] is lead(b)'s offset and out_bank_data[b] is lead(b)'s data; both are 0 when bank b is not enabled.
- out_lane_mask is the OR of the served lanes over all banks.
- out_last=1 iff (pending & ~out_lane_mask)==0.
- On out_valid && out_ready: pending <= pending & ~out_lane_mask. If out_last, go to IDLE.
- If out_ready=0, every output and all state hold stable.
- Stores with the same bank and offset are issued in ascending lane order, so the highest lane's data lands last.
- in_mask==0: exactly one beat with out_bank_enable=0, out_lane_mask=0, out_last=1.
- Beat count = max over banks of the distinct-offset groups (load) or the lane count (store) in that bank.
- Reset asserted mid-ISSUE: the request is dropped, with no further beats.

Decomposition:
- npu_spm_defines.sv already holds sm_bank_address_t, sm_entry_address_t, `SM_PROCESSING_ELEMENTS and `SM_MEMORY_BANKS.
- Add to npu_spm_defines.sv:
  - the typedef sm_serializer_state_t {IDLE, ISSUE};
  - the beat struct sm_bank_issue_t {enable, offset, data}.
- Sub-module spm_bank_lead_select (combinational, one instance per bank): inputs are pending, bank_indexes, bank_offsets, is_store and bank id; outputs are lead-valid, lead lane index and served-lane mask. It uses priority_encoder_npu with MAX_PRIORITY "LSB".

Test Plan:
- Load, mask 0xFFFF, lane i -> bank i, offset 0 -> one beat: out_bank_enable 0xFFFF, out_lane_mask 0xFFFF, out_last 1; in_ready returns at T+2.
- Load, all lanes bank 3 offset 7 -> one beat: out_bank_enable 0x0008, out_bank_offset[3]=7, out_lane_mask 0xFFFF.
- Load, lanes 0-7 bank 0 offset 1, lanes 8-15 bank 0 offset 2 -> beat 1 lane mask 0x00FF (last 0); beat 2 lane mask 0xFF00 (last 1).
- Store, mask 0xFFFF, all lanes bank 2 offset 5, data = lane id -> 16 beats with lane mask 1<<k in order; out_bank_data[2]=k on beat k; out_last only on the 16th beat.
- Back-pressure: hold out_ready=0 for 3 cycles during beat 1 of the previous scenario -> all outputs stable and pending unchanged; sequence resumes on release.
- Zero mask -> one beat with enable 0, lane mask 0, last 1. Separately, pulse reset=0 mid-way through the store sequence -> out_valid=0 and in_ready=1 immediately, with no further beats.

Source files
------------

// File: rtl/spm_conflict_serializer_pkg.sv
// Shared types and sizing for the scratchpad conflict serializer.
`ifndef SM_PROCESSING_ELEMENTS
`define SM_PROCESSING_ELEMENTS 16
`endif
`ifndef SM_MEMORY_BANKS
`define SM_MEMORY_BANKS 16
`endif

package spm_conflict_serializer_pkg;

  localparam int SM_NUM_LANES = `SM_PROCESSING_ELEMENTS;
  localparam int SM_NUM_BANKS = `SM_MEMORY_BANKS;
  localparam int SM_BANK_W    = $clog2(SM_NUM_BANKS);
  localparam int SM_ENTRY_W   = 8;
  localparam int SM_DATA_W    = 32;

  typedef logic [SM_BANK_W-1:0]  sm_bank_address_t;
  typedef logic [SM_ENTRY_W-1:0] sm_entry_address_t;

  // IDLE  : waiting for a request, in_ready high
  // ISSUE : draining the pending-lane mask one beat at a time
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sm_serializer_state_t;

  // One bank's slot in an issue beat
  typedef struct packed {
    logic                   enable;
    sm_entry_address_t      offset;
    logic [SM_DATA_W-1:0]   data;
  } sm_bank_issue_t;

endpackage

// File: rtl/priority_encoder_npu.sv
// Priority encoder: index of the highest-priority set bit, LSB- or MSB-first.
module priority_encoder_npu #(
  parameter int    WIDTH        = 16,
  parameter string MAX_PRIORITY = "LSB",
  localparam int   IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] decode_input,
  output logic [IDX_W-1:0] encode_output,
  output logic             valid_output
);

  assign valid_output = |decode_input;

  generate
    if (MAX_PRIORITY == "LSB") begin : g_lsb
      // Scan downward so the lowest set bit is the last (winning) assignment
      always_comb begin
        encode_output = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (decode_input[i]) encode_output = IDX_W'(i);
        end
      end
    end else begin : g_msb
      // Scan upward so the highest set bit wins
      always_comb begin
        encode_output = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (decode_input[i]) encode_output = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/spm_bank_lead_select.sv
// Per-bank lead-lane picker: finds the lowest pending lane targeting this
// bank and the set of lanes that can share its access this beat.
module spm_bank_lead_select
  import spm_conflict_serializer_pkg::*;
#(
  parameter int  NUM_LANES = SM_NUM_LANES,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] pending_i,
  input  sm_bank_address_t     bank_indexes_i [NUM_LANES],
  input  sm_entry_address_t    bank_offsets_i [NUM_LANES],
  input  logic                 is_store_i,
  input  sm_bank_address_t     bank_id_i,
  output logic                 lead_valid_o,
  output logic [LANE_W-1:0]    lead_lane_o,
  output logic [NUM_LANES-1:0] served_mask_o
);

  logic [NUM_LANES-1:0] hit;
  sm_entry_address_t    lead_offset;

  // Pending lanes that address this bank
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit[i] = pending_i[i] && (bank_indexes_i[i] == bank_id_i);
    end
  end

  priority_encoder_npu #(
    .WIDTH        (NUM_LANES),
    .MAX_PRIORITY ("LSB")
  ) u_lead_enc (
    .decode_input  (hit),
    .encode_output (lead_lane_o),
    .valid_output  (lead_valid_o)
  );

  assign lead_offset = bank_offsets_i[lead_lane_o];

  // Loads broadcast to every hit on the lead's entry; stores take the lead only
  always_comb begin
    served_mask_o = '0;
    if (lead_valid_o) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (is_store_i) begin
          served_mask_o[i] = (LANE_W'(i) == lead_lane_o);
        end else begin
          served_mask_o[i] = hit[i] && (bank_offsets_i[i] == lead_offset);
        end
      end
    end
  end

endmodule

// File: rtl/spm_conflict_serializer.sv
// Splits one vector scratchpad request into bank-conflict-free issue beats.
// Beat outputs depend only on registered state, never on the in_* ports.
module spm_conflict_serializer
  import spm_conflict_serializer_pkg::*;
#(
  parameter int  NUM_LANES = SM_NUM_LANES,
  parameter int  NUM_BANKS = SM_NUM_BANKS,
  parameter int  DATA_W    = SM_DATA_W,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_store,
  input  sm_bank_address_t     in_bank_indexes [NUM_LANES],
  input  sm_entry_address_t    in_bank_offsets [NUM_LANES],
  input  logic [DATA_W-1:0]    in_data         [NUM_LANES],
  input  logic [NUM_LANES-1:0] in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_store,
  output logic [NUM_BANKS-1:0] out_bank_enable,
  output sm_entry_address_t    out_bank_offset [NUM_BANKS],
  output logic [DATA_W-1:0]    out_bank_data   [NUM_BANKS],
  output logic [NUM_LANES-1:0] out_lane_mask,
  output logic                 out_last
);

  sm_serializer_state_t state_q, state_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic                 is_store_q;
  sm_bank_address_t     bank_idx_q [NUM_LANES];
  sm_entry_address_t    bank_off_q [NUM_LANES];
  logic [DATA_W-1:0]    data_q     [NUM_LANES];

  logic                 issue_active;
  logic                 accept;
  logic [NUM_BANKS-1:0] lead_valid;
  logic [LANE_W-1:0]    lead_lane   [NUM_BANKS];
  logic [NUM_LANES-1:0] served_mask [NUM_BANKS];
  sm_bank_issue_t       issue       [NUM_BANKS];
  logic [NUM_LANES-1:0] lane_mask;

  assign issue_active = (state_q == ISSUE);
  assign in_ready     = (state_q == IDLE);
  assign accept       = in_valid && in_ready;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      spm_bank_lead_select #(
        .NUM_LANES (NUM_LANES)
      ) u_lead (
        .pending_i      (pending_q),
        .bank_indexes_i (bank_idx_q),
        .bank_offsets_i (bank_off_q),
        .is_store_i     (is_store_q),
        .bank_id_i      (SM_BANK_W'(b)),
        .lead_valid_o   (lead_valid[b]),
        .lead_lane_o    (lead_lane[b]),
        .served_mask_o  (served_mask[b])
      );
    end
  endgenerate

  // Assemble each bank's slot from its lead lane; disabled banks read as zero
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      issue[i] = '0;
      if (issue_active && lead_valid[i]) begin
        issue[i].enable = 1'b1;
        issue[i].offset = bank_off_q[lead_lane[i]];
        issue[i].data   = SM_DATA_W'(data_q[lead_lane[i]]);
      end
    end
  end

  // Union of lanes served across all banks this beat
  always_comb begin
    lane_mask = '0;
    if (issue_active) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        lane_mask = lane_mask | served_mask[i];
      end
    end
  end

  // Drive the beat ports from the assembled slots
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      out_bank_enable[i] = issue[i].enable;
      out_bank_offset[i] = issue[i].offset;
      out_bank_data[i]   = DATA_W'(issue[i].data);
    end
  end

  assign out_valid     = issue_active;
  assign out_is_store  = is_store_q;
  assign out_lane_mask = lane_mask;
  // Gated by state so an idle, empty pending mask never looks like a last beat
  assign out_last      = issue_active && ((pending_q & ~lane_mask) == '0);

  // Next-state: accept in IDLE, retire served lanes on each accepted beat
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = in_mask;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          pending_d = pending_q & ~lane_mask;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Request capture registers, loaded only on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        bank_idx_q[i] <= '0;
        bank_off_q[i] <= '0;
        data_q[i]     <= '0;
      end
    end else if (accept) begin
      is_store_q <= in_is_store;
      for (int i = 0; i < NUM_LANES; i++) begin
        bank_idx_q[i] <= in_bank_indexes[i];
        bank_off_q[i] <= in_bank_offsets[i];
        data_q[i]     <= in_data[i];
      end
    end
  end

endmodule

// File: tb/tb_spm_conflict_serializer.sv
// Directed bench for the scratchpad conflict serializer.
module tb_spm_conflict_serializer;
  import spm_conflict_serializer_pkg::*;

  localparam int NL = 16;
  localparam int NB = 16;
  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_is_store;
  sm_bank_address_t  in_bank_indexes [NL];
  sm_entry_address_t in_bank_offsets [NL];
  logic [DW-1:0]     in_data         [NL];
  logic [NL-1:0]     in_mask;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_store;
  logic [NB-1:0]     out_bank_enable;
  sm_entry_address_t out_bank_offset [NB];
  logic [DW-1:0]     out_bank_data   [NB];
  logic [NL-1:0]     out_lane_mask;
  logic              out_last;

  int vectors;
  int miscompares;

  spm_conflict_serializer #(
    .NUM_LANES (NL),
    .NUM_BANKS (NB),
    .DATA_W    (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_is_store     (in_is_store),
    .in_bank_indexes (in_bank_indexes),
    .in_bank_offsets (in_bank_offsets),
    .in_data         (in_data),
    .in_mask         (in_mask),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_is_store    (out_is_store),
    .out_bank_enable (out_bank_enable),
    .out_bank_offset (out_bank_offset),
    .out_bank_data   (out_bank_data),
    .out_lane_mask   (out_lane_mask),
    .out_last        (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle and let it be accepted
  task automatic send(input logic st, input logic [NL-1:0] m);
    in_is_store = st;
    in_mask     = m;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_is_store = 1'b0;
    in_mask     = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < NL; i++) begin
      in_bank_indexes[i] = '0;
      in_bank_offsets[i] = '0;
      in_data[i]         = '0;
    end
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_enable",    32'(out_bank_enable), 32'h0);
    check("rst_lane_mask", 32'(out_lane_mask), 32'h0);
    check("rst_last",      32'(out_last), 32'h0);
    #2 reset = 1'b1;
    tick();

    // Load, lane i -> bank i, offset 0: one fully parallel beat
    for (int i = 0; i < NL; i++) begin
      in_bank_indexes[i] = sm_bank_address_t'(i);
      in_bank_offsets[i] = '0;
    end
    send(1'b0, 16'hFFFF);
    check("a_valid",    32'(out_valid), 32'h1);
    check("a_in_ready", 32'(in_ready), 32'h0);
    check("a_enable",   32'(out_bank_enable), 32'hFFFF);
    check("a_lanes",    32'(out_lane_mask), 32'hFFFF);
    check("a_last",     32'(out_last), 32'h1);
    check("a_is_store", 32'(out_is_store), 32'h0);
    tick();
    check("a_ready_back", 32'(in_ready), 32'h1);
    check("a_idle_valid", 32'(out_valid), 32'h0);

    // Load, all lanes bank 3 offset 7: broadcast in one beat
    for (int i = 0; i < NL; i++) begin
      in_bank_indexes[i] = 4'd3;
      in_bank_offsets[i] = 8'd7;
    end
    send(1'b0, 16'hFFFF);
    check("b_enable", 32'(out_bank_enable), 32'h0008);
    check("b_offset", 32'(out_bank_offset[3]), 32'd7);
    check("b_lanes",  32'(out_lane_mask), 32'hFFFF);
    check("b_last",   32'(out_last), 32'h1);
    tick();

    // Load, bank 0, two offset groups: two beats
    for (int i = 0; i < NL; i++) begin
      in_bank_indexes[i] = '0;
      in_bank_offsets[i] = (i < 8) ? 8'd1 : 8'd2;
    end
    send(1'b0, 16'hFFFF);
    check("c1_lanes",  32'(out_lane_mask), 32'h00FF);
    check("c1_last",   32'(out_last), 32'h0);
    check("c1_offset", 32'(out_bank_offset[0]), 32'd1);
    tick();
    check("c2_valid",  32'(out_valid), 32'h1);
    check("c2_lanes",  32'(out_lane_mask), 32'hFF00);
    check("c2_last",   32'(out_last), 32'h1);
    check("c2_offset", 32'(out_bank_offset[0]), 32'd2);
    tick();
    check("c_ready_back", 32'(in_ready), 32'h1);

    // Store, all lanes bank 2 offset 5, data = lane id: 16 serial beats,
    // with three stalled cycles on the first beat
    for (int i = 0; i < NL; i++) begin
      in_bank_indexes[i] = 4'd2;
      in_bank_offsets[i] = 8'd5;
      in_data[i]         = 32'(i);
    end
    send(1'b1, 16'hFFFF);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("bp_valid",  32'(out_valid), 32'h1);
      check("bp_lanes",  32'(out_lane_mask), 32'h0001);
      check("bp_enable", 32'(out_bank_enable), 32'h0004);
      check("bp_data",   32'(out_bank_data[2]), 32'd0);
      check("bp_last",   32'(out_last), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < NL; k++) begin
      check("d_is_store", 32'(out_is_store), 32'h1);
      check("d_enable",   32'(out_bank_enable), 32'h0004);
      check("d_lanes",    32'(out_lane_mask), 32'h1 << k);
      check("d_data",     32'(out_bank_data[2]), 32'(k));
      check("d_offset",   32'(out_bank_offset[2]), 32'd5);
      check("d_last",     32'(out_last), (k == NL - 1) ? 32'h1 : 32'h0);
      tick();
    end
    check("d_ready_back", 32'(in_ready), 32'h1);
    check("d_idle_valid", 32'(out_valid), 32'h0);

    // Zero mask: a single empty, last beat
    send(1'b0, 16'h0000);
    check("z_valid",  32'(out_valid), 32'h1);
    check("z_enable", 32'(out_bank_enable), 32'h0);
    check("z_lanes",  32'(out_lane_mask), 32'h0);
    check("z_last",   32'(out_last), 32'h1);
    tick();
    check("z_ready_back", 32'(in_ready), 32'h1);

    // Reset pulse mid-way through a store sequence drops the request
    send(1'b1, 16'hFFFF);
    tick();
    tick();
    tick();
    check("r_pre_lanes", 32'(out_lane_mask), 32'h0008);
    reset = 1'b0;
    #1;
    check("r_valid",    32'(out_valid), 32'h0);
    check("r_in_ready", 32'(in_ready), 32'h1);
    check("r_enable",   32'(out_bank_enable), 32'h0);
    #2 reset = 1'b1;
    tick();
    tick();
    check("r_no_beats", 32'(out_valid), 32'h0);
    check("r_no_lanes", 32'(out_lane_mask), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
